icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped one-word lines (power of two, 4..64).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU fetch request.
REQ-006 req_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 rsp_valid  output  1  one-cycle pulse, instruction valid; CPU always accepts.
REQ-009 rsp_instr  output  32  fetched instruction; 0 when rsp_valid=0.
REQ-010 flush  input  1  pulse, invalidate all lines.
REQ-011 mem_req_valid / mem_req_addr(ADDR_W) / mem_req_ready(input): refill request handshake to backing memory.
REQ-012 mem_rsp_valid(input) / mem_rsp_data(input, 32): refill data return.
REQ-013 hit_cnt, miss_cnt  output  32  accepted-request hit/miss counters.

Function
REQ-014 Index = req_addr[INDEX_W+1:2], tag = req_addr[ADDR_W-1:INDEX_W+2], INDEX_W = log2(LINES).
REQ-015 States IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH.
REQ-016 req_ready = 1 in IDLE, and in LOOKUP when the lookup hits, except when flush or a pending flush is present; 0 in all other states.
REQ-017 On acceptance the controller latches the address and issues a synchronous data-array read; next state LOOKUP.
REQ-018 LOOKUP hit (valid && tag match): rsp_valid=1 with array data in that cycle (latency 1 after acceptance); a request accepted in the same cycle stays in LOOKUP, otherwise IDLE.
REQ-019 LOOKUP miss: no response; next state MISS_REQ.
REQ-020 MISS_REQ: mem_req_valid=1, mem_req_addr = latched address with [1:0]=0, both held stable until mem_req_ready; then MISS_WAIT.
REQ-021 MISS_WAIT: on mem_rsp_valid, write data to the line, set tag and valid, assert rsp_valid with rsp_instr=mem_rsp_data in the same cycle, then go IDLE.
REQ-022 mem_rsp_valid outside MISS_WAIT is ignored.
REQ-023 flush in IDLE (priority over a simultaneous req_valid) enters FLUSH; FLUSH clears all valid bits in one cycle, then IDLE.
REQ-024 flush in LOOKUP/MISS_REQ/MISS_WAIT sets a pending flag; the current fetch completes normally, the flush executes on the next IDLE, and the refilled line ends invalid.
REQ-025 hit_cnt increments per LOOKUP hit, miss_cnt per LOOKUP miss; both wrap modulo 2^32.
REQ-026 Only one refill outstanding; mem_req_valid never asserts outside MISS_REQ.

Reset
REQ-027 rst_n low: state IDLE, all valid bits 0, pending flush 0, counters 0, req_ready 0 while rst_n is low, rsp_valid 0, rsp_instr 0, mem_req_valid 0, mem_req_addr 0.
REQ-028 Reset mid-refill abandons the refill; a later mem_rsp_valid writes nothing.
REQ-029 Data array contents are not reset.

Structure
REQ-030 Shared package icache_pkg holds the state enum, the LINES default and the INDEX_W/TAG_W derivations.
REQ-031 Data storage is the sub-module icache_data_ram: LINES x 32, synchronous read, one write port; tags and valid bits are flops in icache_ctrl.

Verification
REQ-032 Cold fetch of 0x0000_0010, memory returns 0x0020_0513 after 3 cycles -> one mem request to 0x10, rsp 0x0020_0513, miss_cnt=1.
REQ-033 Repeat 0x10 then back-to-back 0x14 (hit) -> responses on consecutive cycles, no memory request, hit_cnt increments by 2.
REQ-034 Fetch 0x10, then 0x50 (same index, different tag) -> second access misses and refills; fetch 0x10 again -> misses.
REQ-035 flush with req_valid in IDLE -> FLUSH taken first, request accepted after it and misses; flush during MISS_WAIT -> refill response delivered, line then invalid.
REQ-036 mem_req_ready held low 5 cycles -> mem_req_valid/addr stable throughout, req_ready=0.
REQ-037 rst_n asserted in MISS_WAIT, then stray mem_rsp_valid -> no rsp_valid, all lines invalid, counters 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINES_DEF  = 16;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FLUSH
  } state_t;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Word-addressed lines: two byte-offset bits sit below the index.
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/icache_if.sv
// CPU fetch port and backing-memory refill port of the instruction cache.
interface icache_cpu_if import icache_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_instr;
  logic              flush;

  modport master (output req_valid, req_addr, flush,
                  input  req_ready, rsp_valid, rsp_instr);
  modport slave  (input  req_valid, req_addr, flush,
                  output req_ready, rsp_valid, rsp_instr);
endinterface

interface icache_mem_if import icache_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  modport master (output mem_req_valid, mem_req_addr,
                  input  mem_req_ready, mem_rsp_valid, mem_rsp_data);
  modport slave  (input  mem_req_valid, mem_req_addr,
                  output mem_req_ready, mem_rsp_valid, mem_rsp_data);
endinterface

// File: rtl/icache_data_ram.sv
// Instruction data array: one synchronous read port, one write port, no reset.
module icache_data_ram import icache_pkg::*; #(
  parameter int LINES  = LINES_DEF,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rd_en,
  input  logic [index_w(LINES)-1:0] rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      we,
  input  logic [index_w(LINES)-1:0] wr_addr,
  input  logic [DATA_W-1:0]         wr_data
);

  logic [DATA_W-1:0] mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller with
// single outstanding refill and deferred flush.
module icache_ctrl import icache_pkg::*; #(
  parameter int LINES  = LINES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int INDEX_W = index_w(LINES);
  localparam int TAG_W   = tag_w(ADDR_W, LINES);

  state_t             state;
  state_t             state_nxt;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic               flush_pend;

  logic [ADDR_W-1:2]  addr_p1;
  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] idx_p1;
  logic [TAG_W-1:0]   tag_p1;
  logic [31:0]        ram_rdata_p1;

  logic               hit;
  logic               fill;
  logic               accept;
  logic               rdy;
  logic               unused_addr_lsb;

  assign req_idx         = cpu.req_addr[INDEX_W+1:2];
  assign idx_p1          = addr_p1[INDEX_W+1:2];
  assign tag_p1          = addr_p1[ADDR_W-1:INDEX_W+2];
  assign unused_addr_lsb = ^cpu.req_addr[1:0];

  assign hit    = (state == ST_LOOKUP) && valid_q[idx_p1] && (tag_q[idx_p1] == tag_p1);
  assign fill   = (state == ST_MISS_WAIT) && mem.mem_rsp_valid;
  assign accept = cpu.req_valid && cpu.req_ready;

  // ---- stage p0 -> p1: accept request, latch address, launch array read
  icache_data_ram #(
    .LINES  (LINES),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (req_idx),
    .rd_data (ram_rdata_p1),
    .we      (fill),
    .wr_addr (idx_p1),
    .wr_data (mem.mem_rsp_data)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= cpu.req_addr[ADDR_W-1:2];
    end
    if (fill) begin
      tag_q[idx_p1] <= tag_p1;
    end
  end

  // ---- stage p1: lookup, refill sequencing, flush
  always_comb begin
    state_nxt         = state;
    rdy               = 1'b0;
    cpu.req_ready     = 1'b0;
    cpu.rsp_valid     = 1'b0;
    cpu.rsp_instr     = '0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_addr  = '0;
    case (state)
      ST_IDLE: begin
        if (cpu.flush || flush_pend) begin
          state_nxt = ST_FLUSH;
        end else begin
          rdy = 1'b1;
          if (cpu.req_valid) begin
            state_nxt = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu.rsp_valid = 1'b1;
          cpu.rsp_instr = ram_rdata_p1;
          rdy           = !cpu.flush && !flush_pend;
          state_nxt     = (cpu.req_valid && rdy) ? ST_LOOKUP : ST_IDLE;
        end else begin
          state_nxt = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = {addr_p1, 2'b00};
        if (mem.mem_req_ready) begin
          state_nxt = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (mem.mem_rsp_valid) begin
          cpu.rsp_valid = 1'b1;
          cpu.rsp_instr = mem.mem_rsp_data;
          state_nxt     = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Asynchronous reset forces IDLE, so ready must also be gated while held.
    cpu.req_ready = rdy && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      valid_q    <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FLUSH) begin
        valid_q    <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (fill) begin
          valid_q[idx_p1] <= 1'b1;
        end
        // A flush seen mid-fetch waits for the next IDLE; IDLE handles it directly.
        if (cpu.flush && (state != ST_IDLE)) begin
          flush_pend <= 1'b1;
        end
      end
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state == ST_LOOKUP) && !hit) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl with hand-computed expectations.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          checks    = 0;
  int          failures  = 0;
  int          mreq_cnt  = 0;

  always #5 clk = ~clk;

  icache_cpu_if #(.ADDR_W(32)) cpu_if ();
  icache_mem_if #(.ADDR_W(32)) mem_if ();

  icache_ctrl #(
    .LINES  (16),
    .ADDR_W (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (cpu_if),
    .mem      (mem_if),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always @(posedge clk) begin
    if (mem_if.mem_req_valid && mem_if.mem_req_ready) mreq_cnt <= mreq_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv_step;
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE at posedge+1; ends in IDLE at posedge+1 after the fill response.
  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] d,
                            input int rdy_dly, input int rsp_dly, input bit fl_wait);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_addr  = a;
    @(negedge clk);
    chk("miss_req_ready", {31'd0, cpu_if.req_ready}, 32'd1);
    drv_step;
    cpu_if.req_valid = 1'b0;
    @(negedge clk);
    chk("miss_lookup_rsp", {31'd0, cpu_if.rsp_valid}, 32'd0);
    drv_step;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("stall_mreq_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
      chk("stall_mreq_addr", mem_if.mem_req_addr, a & 32'hFFFF_FFFC);
      chk("stall_req_ready", {31'd0, cpu_if.req_ready}, 32'd0);
      drv_step;
    end
    mem_if.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mreq_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("mreq_addr", mem_if.mem_req_addr, a & 32'hFFFF_FFFC);
    drv_step;
    mem_if.mem_req_ready = 1'b0;
    cpu_if.flush         = fl_wait;
    for (int i = 1; i < rsp_dly; i++) begin
      @(negedge clk);
      chk("wait_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd0);
      chk("wait_mreq_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
      drv_step;
      cpu_if.flush = 1'b0;
    end
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_data  = d;
    @(negedge clk);
    chk("fill_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd1);
    chk("fill_rsp_instr", cpu_if.rsp_instr, d);
    drv_step;
    mem_if.mem_rsp_valid = 1'b0;
    cpu_if.flush         = 1'b0;
  endtask

  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] d);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_addr  = a;
    @(negedge clk);
    chk("hit_req_ready", {31'd0, cpu_if.req_ready}, 32'd1);
    drv_step;
    cpu_if.req_valid = 1'b0;
    @(negedge clk);
    chk("hit_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd1);
    chk("hit_rsp_instr", cpu_if.rsp_instr, d);
    chk("hit_no_mreq", {31'd0, mem_if.mem_req_valid}, 32'd0);
    drv_step;
  endtask

  initial begin
    rst_n                = 1'b0;
    cpu_if.req_valid     = 1'b1;
    cpu_if.req_addr      = 32'h10;
    cpu_if.flush         = 1'b0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd0);
    chk("rst_rsp_instr", cpu_if.rsp_instr, 32'd0);
    chk("rst_mreq_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
    chk("rst_mreq_addr", mem_if.mem_req_addr, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    cpu_if.req_valid = 1'b0;
    drv_step;
    rst_n = 1'b1;
    drv_step;

    // Cold miss, memory answers on the third wait cycle
    fetch_miss(32'h10, 32'h0020_0513, 0, 3, 1'b0);
    chk("cold_miss_cnt", miss_cnt, 32'd1);
    chk("cold_hit_cnt", hit_cnt, 32'd0);
    chk("cold_mreqs", mreq_cnt, 32'd1);
    fetch_miss(32'h14, 32'h0000_0093, 0, 2, 1'b0);

    // Back-to-back hits on 0x10 then 0x14
    cpu_if.req_valid = 1'b1;
    cpu_if.req_addr  = 32'h10;
    @(negedge clk);
    chk("b2b_ready0", {31'd0, cpu_if.req_ready}, 32'd1);
    drv_step;
    cpu_if.req_addr = 32'h14;
    @(negedge clk);
    chk("b2b_rsp0_valid", {31'd0, cpu_if.rsp_valid}, 32'd1);
    chk("b2b_rsp0_instr", cpu_if.rsp_instr, 32'h0020_0513);
    chk("b2b_ready1", {31'd0, cpu_if.req_ready}, 32'd1);
    drv_step;
    cpu_if.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp1_valid", {31'd0, cpu_if.rsp_valid}, 32'd1);
    chk("b2b_rsp1_instr", cpu_if.rsp_instr, 32'h0000_0093);
    drv_step;
    chk("b2b_hit_cnt", hit_cnt, 32'd2);
    chk("b2b_miss_cnt", miss_cnt, 32'd2);
    chk("b2b_mreqs", mreq_cnt, 32'd2);

    // 0x50 aliases 0x10 at index 4
    fetch_miss(32'h50, 32'h1111_1111, 0, 1, 1'b0);
    fetch_miss(32'h10, 32'h0020_0513, 0, 1, 1'b0);
    fetch_hit(32'h10, 32'h0020_0513);
    fetch_hit(32'h14, 32'h0000_0093);
    chk("alias_miss_cnt", miss_cnt, 32'd4);
    chk("alias_hit_cnt", hit_cnt, 32'd4);
    chk("alias_mreqs", mreq_cnt, 32'd4);

    // Flush wins over a simultaneous request in IDLE
    cpu_if.flush     = 1'b1;
    cpu_if.req_valid = 1'b1;
    cpu_if.req_addr  = 32'h14;
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    drv_step;
    cpu_if.flush = 1'b0;
    @(negedge clk);
    chk("flush_state_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    drv_step;
    fetch_miss(32'h14, 32'h0000_0093, 0, 1, 1'b0);
    chk("flush_miss_cnt", miss_cnt, 32'd5);
    chk("flush_hit_cnt", hit_cnt, 32'd4);

    // Flush during refill wait: response still delivered, then line invalid
    fetch_miss(32'h20, 32'hAAAA_5555, 0, 3, 1'b1);
    @(negedge clk);
    chk("pend_idle_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    drv_step;
    @(negedge clk);
    chk("pend_flush_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    drv_step;
    fetch_miss(32'h20, 32'hAAAA_5555, 0, 1, 1'b0);
    chk("pend_miss_cnt", miss_cnt, 32'd7);
    chk("pend_hit_cnt", hit_cnt, 32'd4);

    // Refill request back-pressured for 5 cycles; byte offset bits dropped
    fetch_miss(32'h33, 32'h1234_5678, 5, 1, 1'b0);
    fetch_hit(32'h30, 32'h1234_5678);
    chk("stall_miss_cnt", miss_cnt, 32'd8);
    chk("stall_hit_cnt", hit_cnt, 32'd5);

    // Reset while waiting for refill data, then a stray response
    cpu_if.req_valid = 1'b1;
    cpu_if.req_addr  = 32'h40;
    drv_step;
    cpu_if.req_valid = 1'b0;
    drv_step;
    mem_if.mem_req_ready = 1'b1;
    drv_step;
    mem_if.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("midrst_wait_mreq", {31'd0, mem_if.mem_req_valid}, 32'd0);
    drv_step;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_hit_cnt", hit_cnt, 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    chk("midrst_ready", {31'd0, cpu_if.req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd0);
    drv_step;
    rst_n                = 1'b1;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_rsp_valid", {31'd0, cpu_if.rsp_valid}, 32'd0);
    chk("stray_rsp_instr", cpu_if.rsp_instr, 32'd0);
    drv_step;
    mem_if.mem_rsp_valid = 1'b0;
    fetch_miss(32'h30, 32'h1234_5678, 0, 1, 1'b0);
    fetch_miss(32'h40, 32'h0BAD_F00D, 0, 1, 1'b0);
    chk("post_rst_miss_cnt", miss_cnt, 32'd2);
    chk("post_rst_hit_cnt", hit_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
